// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Collects a length-prefixed byte stream and writes 19-bit words from address 0.
//
// Ports:
//   clk, reset                  - system clock, synchronous active-high reset
//   byte_valid/byte_data/byte_ready - incoming byte stream (valid/ready)
//   imem_we/imem_addr/imem_wdata    - instruction-memory write port
//   cpu_reset                   - holds the processor in reset until load completes
//   done, error                 - sticky completion / abort flags
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte that makes the XOR of every accepted byte equal 8'h00.

module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [18:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once all words are written (or N = 0).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t state, state_n;

    logic [7:0]      len_hi;
    logic [15:0]     len;
    logic [ADDR_W:0] idx;
    logic [18:0]     word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    logic        ready_q;
    logic        we_q;
    logic        cpu_rst_q;
    logic        done_q;
    logic        err_q;

    logic        accept;
    logic [15:0] len_n;
    logic        last;
    logic        ready_n;

    assign accept = byte_valid && byte_ready;
    assign len_n  = {len_hi, byte_data};
    // Index is one bit wider than the address so N = 2^ADDR_W ends cleanly.
    assign last   = (17'(idx) + 17'd1) == 17'(len);

    always_comb begin
        state_n = state;
        unique case (state)
            S_LEN_HI: if (accept) state_n = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (17'(len_n) > CAP)
                        state_n = S_ERR;
                    else if (len_n == 16'd0)
                        state_n = S_TAIL;
                    else
                        state_n = S_B0;
                end
            end
            S_B0:    if (accept) state_n = S_B1;
            S_B1:    if (accept) state_n = S_B2;
            S_B2:    if (accept) state_n = S_WRITE;
            S_WRITE: state_n = last ? S_TAIL : S_B0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_n = ((csum ^ byte_data) == 8'h00) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  state_n = S_DONE;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    always_comb begin
        ready_n = 1'b0;
        unique case (state_n)
            S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2: ready_n = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: ready_n = 1'b1;
`endif
            default: ready_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_LEN_HI;
        else
            state <= state_n;
    end

    // Outputs are flops loaded from the next state, so they hold their
    // reset values through the whole reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q   <= ready_n;
            we_q      <= state_n == S_WRITE;
            cpu_rst_q <= state_n != S_DONE;
            done_q    <= state_n == S_DONE;
            err_q     <= state_n == S_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi <= '0;
            len    <= '0;
            idx    <= '0;
            word   <= '0;
        end else begin
            if (accept) begin
                unique case (state)
                    S_LEN_HI: len_hi       <= byte_data;
                    S_LEN_LO: len          <= len_n;
                    S_B0:     word[18:16]  <= byte_data[2:0];
                    S_B1:     word[15:8]   <= byte_data;
                    S_B2:     word[7:0]    <= byte_data;
                    default:  ;
                endcase
            end
            if (state == S_WRITE)
                idx <= idx + 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            csum <= '0;
        else if (accept)
            csum <= csum ^ byte_data;
    end
`endif

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = idx[ADDR_W-1:0];
    assign imem_wdata = word;
    assign cpu_reset  = cpu_rst_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// A stream-level model predicts writes and the final done/error outcome.

module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [18:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  stream[$];
    logic [31:0] got_w[$];
    logic [31:0] exp_w[$];
    bit          exp_done;
    bit          exp_err;

    int cyc = 0;
    int last_we_cyc;
    int first_done_cyc;
    int rel_cyc;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            got_w.push_back((32'(imem_addr) << 19) | 32'(imem_wdata));
            last_we_cyc = cyc;
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
        end
        if (done && first_done_cyc < 0)
            first_done_cyc = cyc;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        @(negedge clk);
        check("rst_ready", 32'(byte_ready), 0);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", 32'(imem_wdata), 0);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        @(negedge clk);
        reset = 1'b0;
        rel_cyc = cyc;
        first_done_cyc = -1;
    endtask

    task automatic build(input int n);
        logic [7:0] x;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int k = 0; k < 3 * n; k++)
            stream.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (stream[k]) x ^= stream[k];
        stream.push_back(x);
`endif
    endtask

    // Stream-level reference: what the bytes mean, not how they are parsed.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_w.delete();
        n = {stream[0], stream[1]};
        exp_err = 1'b0;
        exp_done = 1'b0;
        if (n > CAP) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            int w;
            w = ((stream[2 + 3*k] & 8'h07) << 16)
              | (stream[3 + 3*k] << 8)
              | stream[4 + 3*k];
            exp_w.push_back((32'(k) << 19) | 32'(w));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int k = 0; k < 3 + 3*n; k++) x ^= stream[k];
        exp_done = (x == 8'h00);
        exp_err  = !exp_done;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic drive(input int pct);
        int i = 0;
        int t = 0;
        bit acc;
        while (i < stream.size() && t < 5000) begin
            byte_data  = stream[i];
            byte_valid = ($urandom_range(99) < pct);
            acc = byte_valid && byte_ready;
            @(negedge clk);
            t++;
            if (acc) i++;
        end
        byte_valid = 1'b0;
        if (i < stream.size())
            check("drive_timeout", i, stream.size());
    endtask

    task automatic run(input string tag, input int pct);
        int t = 0;
        do_reset();
        got_w.delete();
        model();
        drive(pct);
        while (!(done || error) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_finished"}, 32'(done || error), 1);
        check({tag, "_nwrites"}, got_w.size(), exp_w.size());
        for (int k = 0; k < got_w.size() && k < exp_w.size(); k++)
            check($sformatf("%s_w%0d", tag, k), got_w[k], exp_w[k]);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({tag, "_ready"}, 32'(byte_ready), 0);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check({tag, "_post_nwrites"}, got_w.size(), exp_w.size());
        check({tag, "_post_done"}, 32'(done), 32'(exp_done));
    endtask

    initial begin
        reset = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        first_done_cyc = -1;
        last_we_cyc = 0;

        do_reset();
        check("ready_still_low", 32'(byte_ready), 0);
        @(negedge clk);
        check("ready_rises", 32'(byte_ready), 1);

        // Directed two-word load with continuous valid.
        stream = {8'h00, 8'h02, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h23);
`endif
        begin
            logic [7:0] s[$];
            s = stream;
            do_reset();
            stream = s;
        end
        run("n2", 100);
        check("n2_addr0", got_w.size() > 0 ? got_w[0] : 0, 32'h0007FFFF);
        check("n2_addr1", got_w.size() > 1 ? got_w[1] : 0,
              (32'd1 << 19) | 32'h01234);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("n2_done_lat", first_done_cyc - last_we_cyc, 2);
`else
        check("n2_done_lat", first_done_cyc - last_we_cyc, 1);
`endif

        // Empty load.
        build(0);
        run("n0", 100);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("n0_done_lat", first_done_cyc - rel_cyc, 4);
`else
        check("n0_done_lat", first_done_cyc - rel_cyc, 3);
`endif

        // Oversized lengths.
        stream = {8'h01, 8'h01};
        run("n257", 100);
        stream = {8'hFF, 8'hFF};
        run("n65535", 100);

        // Full capacity, no address wrap.
        build(CAP);
        run("ncap", 100);

        // Four words with 50% valid, then a few random sizes.
        build(4);
        run("n4_rand", 50);
        for (int r = 0; r < 4; r++) begin
            build($urandom_range(1, 9));
            run($sformatf("rand%0d", r), $urandom_range(30, 100));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        build(3);
        stream[stream.size() - 1] ^= 8'h01;
        run("bad_csum", 100);
`endif

        // Reset after two bytes of the second word.
        build(2);
        model();
        begin
            logic [7:0] full[$];
            logic [31:0] w0;
            full = stream;
            w0 = exp_w[0];
            do_reset();
            got_w.delete();
            stream = full[0:6];
            drive(100);
            repeat (2) @(negedge clk);
            check("mid_nwrites_before", got_w.size(), 1);
            check("mid_w0", got_w.size() > 0 ? got_w[0] : 0, w0);
            do_reset();
            check("mid_nwrites_after", got_w.size(), 1);
            stream = full;
        end
        run("after_mid", 70);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
